// File: rtl/miner_core_sha_engine.sv
// Iterative SHA-256 compression engine: RPC rounds per clock, 16-word rolling
// schedule window, optional second pass over the digest (SHA256d).
module miner_core_sha_engine #(
    parameter int RPC       = 1,
    parameter int DOUBLE_EN = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dbl,
    input  logic [0:511]     chunk,
    input  logic [0:7][0:31] fh,
    output logic             busy,
    output logic             done,
    output logic [0:255]     h
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_ADD   = 2'd2;

    localparam logic [6:0] LAST_RCNT = 7'(64 - RPC);
    localparam logic [6:0] RPC_STEP  = 7'(RPC);

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [1:0]  state_reg;
    logic [6:0]  rcnt_reg;
    logic        pass2_reg;
    logic        dbl_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [255:0] h_reg;
    logic [31:0] w_reg     [0:15];
    logic [31:0] work_reg  [0:7];
    logic [31:0] hsave_reg [0:7];

    logic [31:0] ext  [0:15+RPC];
    logic [31:0] rnd  [0:7];
    logic [31:0] sum_w [0:7];

    // ext[0..15] is the current window W[rcnt..rcnt+15]; ext[16..] extends it
    // by RPC freshly scheduled words so the window can slide by RPC per edge.
    always_comb begin
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = '0;
        t2 = '0;
        for (int i = 0; i < 16; i++) begin
            ext[i] = w_reg[i];
        end
        for (int j = 0; j < RPC; j++) begin
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 8; i++) begin
            rnd[i] = work_reg[i];
        end
        for (int j = 0; j < RPC; j++) begin
            t1 = rnd[7] + bsig1(rnd[4]) + ((rnd[4] & rnd[5]) ^ (~rnd[4] & rnd[6]))
                 + K_TAB[rcnt_reg[5:0] + 6'(j)] + ext[j];
            t2 = bsig0(rnd[0]) + ((rnd[0] & rnd[1]) ^ (rnd[0] & rnd[2]) ^ (rnd[1] & rnd[2]));
            rnd[7] = rnd[6];
            rnd[6] = rnd[5];
            rnd[5] = rnd[4];
            rnd[4] = rnd[3] + t1;
            rnd[3] = rnd[2];
            rnd[2] = rnd[1];
            rnd[1] = rnd[0];
            rnd[0] = t1 + t2;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sum
            assign sum_w[gi] = hsave_reg[gi] + work_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= S_IDLE;
            rcnt_reg  <= '0;
            pass2_reg <= 1'b0;
            dbl_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            h_reg     <= '0;
            for (int i = 0; i < 16; i++) w_reg[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                work_reg[i]  <= '0;
                hsave_reg[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                pass2_reg <= 1'b0;
                rcnt_reg  <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            for (int i = 0; i < 16; i++) w_reg[i] <= chunk[i*32 +: 32];
                            for (int i = 0; i < 8; i++) begin
                                work_reg[i]  <= fh[i];
                                hsave_reg[i] <= fh[i];
                            end
                            dbl_reg   <= (DOUBLE_EN != 0) && dbl;
                            pass2_reg <= 1'b0;
                            rcnt_reg  <= '0;
                            busy_reg  <= 1'b1;
                            state_reg <= S_ROUND;
                        end
                    end
                    S_ROUND: begin
                        for (int i = 0; i < 16; i++) w_reg[i] <= ext[i+RPC];
                        for (int i = 0; i < 8; i++) work_reg[i] <= rnd[i];
                        rcnt_reg <= rcnt_reg + RPC_STEP;
                        if (rcnt_reg == LAST_RCNT) state_reg <= S_ADD;
                    end
                    S_ADD: begin
                        if (!pass2_reg && dbl_reg) begin
                            // Second pass hashes the 256-bit digest as a padded one-block message.
                            for (int i = 0; i < 8; i++) begin
                                w_reg[i]     <= sum_w[i];
                                work_reg[i]  <= IV[i];
                                hsave_reg[i] <= IV[i];
                            end
                            w_reg[8] <= 32'h80000000;
                            for (int i = 9; i < 15; i++) w_reg[i] <= '0;
                            w_reg[15] <= 32'h00000100;
                            pass2_reg <= 1'b1;
                            rcnt_reg  <= '0;
                            state_reg <= S_ROUND;
                        end else begin
                            for (int i = 0; i < 8; i++) h_reg[255-32*i -: 32] <= sum_w[i];
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            pass2_reg <= 1'b0;
                            rcnt_reg  <= '0;
                            state_reg <= S_IDLE;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign h    = h_reg;

endmodule
